// File: rtl/cim_pkg.sv
// Shared constants and state types for the CIM scheduler.
//   N_CORE/CORE_AW : number of CIM cores and the core address width
//   ROWS/ROW_AW    : weight rows per core and the row address width
//   W_WIDTH        : width of one weight row (72 x 4b)
//   BEAT_W         : width of the activation beat count
package cim_pkg;
  localparam int N_CORE  = 8;
  localparam int CORE_AW = 3;
  localparam int ROWS    = 64;
  localparam int ROW_AW  = 6;
  localparam int W_WIDTH = 288;
  localparam int BEAT_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} st_state_t;
  typedef enum logic {C_IDLE, C_RUN} cmp_state_t;
endpackage

// File: rtl/cim_psum_delay.sv
// Models the CIM unit's PSUM latency: a PSUM_LAT-deep shift register that
// turns the activation strobe into psum_valid and the last-beat flag into
// cmp_done.
//   clk, rst   : clock, asynchronous active-high reset
//   act_en     : activation beat strobe presented to the CIM unit
//   act_last   : act_en qualified with "this is the final beat"
//   psum_valid : act_en delayed by PSUM_LAT cycles
//   cmp_done   : act_last delayed by PSUM_LAT cycles
module cim_psum_delay #(
  parameter int PSUM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic act_en,
  input  logic act_last,
  output logic psum_valid,
  output logic cmp_done
);
  logic [PSUM_LAT-1:0] v_pipe;
  logic [PSUM_LAT-1:0] l_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe[0] <= act_en;
      l_pipe[0] <= act_last;
      for (int i = 1; i < PSUM_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
    end
  end

  assign psum_valid = v_pipe[PSUM_LAT-1];
  assign cmp_done   = l_pipe[PSUM_LAT-1];
endmodule

// File: rtl/cim_sched.sv
// Scheduler in front of the CIM unit. Runs a storage engine (64-row weight
// load or single-row readback over the standby port) and a compute engine
// (N activation beats) concurrently, enforcing ping-pong use of the cores and
// tracking per-core weight validity.
//   ld_start/ld_core, w_valid/w_ready/w_data : weight load request and beats
//   rd_req/rd_core/rd_row, rd_valid          : single-row readback
//   cmp_start/cmp_core/cmp_beats             : compute request
//   psum_valid, cmp_done                     : PSUM timing, final PSUM pulse
//   busy_ld, busy_cmp, err_reject            : engine status, reject pulse
//   core_valid                               : bitmap of fully loaded cores
//   STDW/STDR/STD_Core_A/STD_row_A/weight_in : registered standby port
//   CIM_Core_A, act_en                       : registered compute port
//
// Handshake: a weight beat transfers on every rising edge where
// w_valid & w_ready; w_ready is high exactly while the load engine is active,
// w_valid may drop at any time (the row is simply held), and w_data need only
// be stable on transfer cycles.
module cim_sched
  import cim_pkg::*;
#(
  parameter int PSUM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_start,
  input  logic [CORE_AW-1:0] ld_core,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [W_WIDTH-1:0] w_data,
  input  logic               rd_req,
  input  logic [CORE_AW-1:0] rd_core,
  input  logic [ROW_AW-1:0]  rd_row,
  output logic               rd_valid,
  input  logic               cmp_start,
  input  logic [CORE_AW-1:0] cmp_core,
  input  logic [BEAT_W-1:0]  cmp_beats,
  output logic               psum_valid,
  output logic               cmp_done,
  output logic               busy_ld,
  output logic               busy_cmp,
  output logic               err_reject,
  output logic [N_CORE-1:0]  core_valid,
  output logic               STDW,
  output logic               STDR,
  output logic [CORE_AW-1:0] STD_Core_A,
  output logic [ROW_AW-1:0]  STD_row_A,
  output logic [W_WIDTH-1:0] weight_in,
  output logic [CORE_AW-1:0] CIM_Core_A,
  output logic               act_en
);
  st_state_t          st_state, st_nxt;
  cmp_state_t         cmp_state, cs_nxt;
  logic [ROW_AW-1:0]  row_cnt, row_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
  logic [CORE_AW-1:0] core_a_nxt, cim_nxt;
  logic [ROW_AW-1:0]  row_a_nxt;
  logic [W_WIDTH-1:0] wdat_nxt;
  logic [N_CORE-1:0]  valid_nxt;
  logic stdw_nxt, stdr_nxt, rdv_nxt, act_nxt, busy_nxt, err_nxt;
  logic ld_ok, rd_ok, cmp_ok, act_last;

  // Compute is judged first; a load aimed at the core that compute grabs in
  // the same cycle, or at the core currently computing, is a conflict.
  always_comb begin
    cmp_ok = cmp_start && !busy_cmp && (cmp_beats != '0) && core_valid[cmp_core];
    ld_ok  = ld_start && (st_state == S_IDLE)
             && !(busy_cmp && (ld_core == CIM_Core_A))
             && !(cmp_ok && (cmp_core == ld_core));
    rd_ok  = rd_req && (st_state == S_IDLE) && !ld_start;
    err_nxt = (ld_start && !ld_ok) || (rd_req && !rd_ok) || (cmp_start && !cmp_ok);
  end

  // Storage engine next state and registered standby-port values.
  always_comb begin
    st_nxt     = st_state;
    row_nxt    = row_cnt;
    core_a_nxt = STD_Core_A;
    row_a_nxt  = STD_row_A;
    wdat_nxt   = weight_in;
    valid_nxt  = core_valid;
    stdw_nxt   = 1'b0;
    stdr_nxt   = 1'b0;
    rdv_nxt    = 1'b0;
    case (st_state)
      S_IDLE: begin
        if (ld_ok) begin
          st_nxt             = S_LOAD;
          core_a_nxt         = ld_core;
          row_nxt            = '0;
          valid_nxt[ld_core] = 1'b0;
        end else if (rd_ok) begin
          st_nxt     = S_READ;
          stdr_nxt   = 1'b1;
          core_a_nxt = rd_core;
          row_a_nxt  = rd_row;
        end
      end
      S_LOAD: begin
        if (w_valid) begin
          stdw_nxt  = 1'b1;
          row_a_nxt = row_cnt;
          wdat_nxt  = w_data;
          // Wraps to 0 after the final row.
          row_nxt   = row_cnt + ROW_AW'(1);
          if (row_cnt == ROW_AW'(ROWS - 1)) begin
            valid_nxt[STD_Core_A] = 1'b1;
            st_nxt                = S_IDLE;
          end
        end
      end
      S_READ: begin
        rdv_nxt = 1'b1;
        st_nxt  = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Compute engine: act_en is high while in C_RUN; beat_cnt counts the
  // remaining beats including the current one.
  always_comb begin
    cs_nxt   = cmp_state;
    beat_nxt = beat_cnt;
    cim_nxt  = CIM_Core_A;
    act_nxt  = 1'b0;
    busy_nxt = busy_cmp;
    case (cmp_state)
      C_IDLE: begin
        if (cmp_ok) begin
          cs_nxt   = C_RUN;
          cim_nxt  = cmp_core;
          beat_nxt = cmp_beats;
          act_nxt  = 1'b1;
        end
      end
      C_RUN: begin
        beat_nxt = beat_cnt - BEAT_W'(1);
        if (beat_cnt == BEAT_W'(1)) cs_nxt = C_IDLE;
        else act_nxt = 1'b1;
      end
      default: cs_nxt = C_IDLE;
    endcase
    // busy_cmp covers the PSUM tail and drops right after cmp_done.
    if (cmp_ok) busy_nxt = 1'b1;
    else if (cmp_done) busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state   <= S_IDLE;
      cmp_state  <= C_IDLE;
      row_cnt    <= '0;
      beat_cnt   <= '0;
      STD_Core_A <= '0;
      STD_row_A  <= '0;
      weight_in  <= '0;
      core_valid <= '0;
      STDW       <= 1'b0;
      STDR       <= 1'b0;
      rd_valid   <= 1'b0;
      CIM_Core_A <= '0;
      act_en     <= 1'b0;
      busy_cmp   <= 1'b0;
      err_reject <= 1'b0;
    end else begin
      st_state   <= st_nxt;
      cmp_state  <= cs_nxt;
      row_cnt    <= row_nxt;
      beat_cnt   <= beat_nxt;
      STD_Core_A <= core_a_nxt;
      STD_row_A  <= row_a_nxt;
      weight_in  <= wdat_nxt;
      core_valid <= valid_nxt;
      STDW       <= stdw_nxt;
      STDR       <= stdr_nxt;
      rd_valid   <= rdv_nxt;
      CIM_Core_A <= cim_nxt;
      act_en     <= act_nxt;
      busy_cmp   <= busy_nxt;
      err_reject <= err_nxt;
    end
  end

  assign w_ready  = (st_state == S_LOAD);
  assign busy_ld  = (st_state != S_IDLE);
  assign act_last = act_en && (beat_cnt == BEAT_W'(1));

  cim_psum_delay #(.PSUM_LAT(PSUM_LAT)) u_psum (
    .clk        (clk),
    .rst        (rst),
    .act_en     (act_en),
    .act_last   (act_last),
    .psum_valid (psum_valid),
    .cmp_done   (cmp_done)
  );
endmodule

// File: tb/tb_cim_sched.sv
// Bench for cim_sched: directed scenarios plus randomized load/compute/read
// traffic, checked against a transaction-level model (expected write queue,
// expected core-valid bitmap, beat timing derived from the request).
module tb_cim_sched;
  localparam int LAT = 2;
  localparam int ROWS = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld_start = 1'b0;
  logic [2:0]   ld_core = '0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [287:0] w_data = '0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_core = '0;
  logic [5:0]   rd_row = '0;
  logic         rd_valid;
  logic         cmp_start = 1'b0;
  logic [2:0]   cmp_core = '0;
  logic [7:0]   cmp_beats = '0;
  logic         psum_valid, cmp_done, busy_ld, busy_cmp, err_reject;
  logic [7:0]   core_valid;
  logic         STDW, STDR;
  logic [2:0]   STD_Core_A;
  logic [5:0]   STD_row_A;
  logic [287:0] weight_in;
  logic [2:0]   CIM_Core_A;
  logic         act_en;

  cim_sched #(.PSUM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_core(ld_core),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .rd_req(rd_req), .rd_core(rd_core), .rd_row(rd_row), .rd_valid(rd_valid),
    .cmp_start(cmp_start), .cmp_core(cmp_core), .cmp_beats(cmp_beats),
    .psum_valid(psum_valid), .cmp_done(cmp_done),
    .busy_ld(busy_ld), .busy_cmp(busy_cmp), .err_reject(err_reject),
    .core_valid(core_valid),
    .STDW(STDW), .STDR(STDR), .STD_Core_A(STD_Core_A), .STD_row_A(STD_row_A),
    .weight_in(weight_in), .CIM_Core_A(CIM_Core_A), .act_en(act_en)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int n_stdw = 0;
  logic [7:0]   exp_valid = '0;
  logic [296:0] exp_q[$];   // {core, row, data} per expected STDW
  logic [287:0] ones;
  logic [29:0]  ctl_vec;

  assign ctl_vec = {w_ready, rd_valid, psum_valid, cmp_done, busy_ld, busy_cmp,
                    err_reject, STDW, STDR, act_en, core_valid, STD_Core_A,
                    STD_row_A, CIM_Core_A};

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && STDW) begin
      n_stdw++;
      if (exp_q.size() == 0) chk("stdw_extra", STDW, 1'b0);
      else begin
        logic [296:0] e;
        e = exp_q.pop_front();
        chk("std_core", STD_Core_A, e[296:294]);
        chk("std_row", STD_row_A, e[293:288]);
        chk("weight_in", weight_in, e[287:0]);
      end
    end
    if (!rst) chk("core_valid", core_valid, exp_valid);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [287:0] rand_row();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic issue(input logic ld, input int lc, input logic rd, input int rc,
                       input int rr, input logic cs, input int cc, input int cb,
                       input logic exp_err, input string tag);
    @(negedge clk);
    ld_start = ld;  ld_core = 3'(lc);
    rd_req = rd;    rd_core = 3'(rc); rd_row = 6'(rr);
    cmp_start = cs; cmp_core = 3'(cc); cmp_beats = 8'(cb);
    @(posedge clk);
    #1;
    ld_start = 1'b0; rd_req = 1'b0; cmp_start = 1'b0;
    chk({tag, "_err"}, err_reject, exp_err);
  endtask

  // mode 0: back-to-back, 1: toggling valid, 2: random gaps.
  task automatic run_load(input int core, input int mode, input int stop_at,
                          input logic use_ones, output int ncyc);
    int acc;
    logic v, rdy;
    logic [287:0] d;
    acc = 0;
    ncyc = 0;
    while (acc < stop_at && ncyc < 1000) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((ncyc % 2) == 0) : ($urandom_range(0, 2) != 0);
      d = use_ones ? ones : rand_row();
      w_valid = v;
      w_data = d;
      rdy = w_ready;
      @(posedge clk);
      if (v && rdy) begin
        exp_q.push_back({3'(core), 6'(acc), d});
        acc++;
        if (acc == ROWS) exp_valid[core] = 1'b1;
      end
      ncyc++;
    end
    #1 w_valid = 1'b0;
    chk("ld_beats", acc, stop_at);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cmp(input int core, input int beats);
    for (int k = 0; k < beats + LAT + 2; k++) begin
      @(negedge clk);
      chk("act_en", act_en, k < beats);
      chk("psum_valid", psum_valid, (k >= LAT) && (k < beats + LAT));
      chk("cmp_done", cmp_done, k == beats + LAT - 1);
      chk("busy_cmp", busy_cmp, k < beats + LAT);
      if (k < beats) chk("cim_core", CIM_Core_A, core);
    end
  endtask

  task automatic do_read(input int core, input int row);
    issue(0, 0, 1, core, row, 0, 0, 0, 1'b0, "rd");
    chk("stdr_on", STDR, 1'b1);
    chk("rd_core", STD_Core_A, core);
    chk("rd_row", STD_row_A, row);
    chk("rd_valid_early", rd_valid, 1'b0);
    @(posedge clk); #1;
    chk("stdr_off", STDR, 1'b0);
    chk("rd_valid", rd_valid, 1'b1);
    @(posedge clk); #1;
    chk("rd_valid_end", rd_valid, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nc, n0;
    ones = {72{4'h1}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_vec, 30'h0);
    chk("reset_wdata", weight_in, 288'h0);
    @(negedge clk) rst = 1'b0;

    // full back-to-back load of core 4
    issue(1, 4, 0, 0, 0, 0, 0, 0, 1'b0, "ld4");
    chk("busy_ld_on", busy_ld, 1'b1);
    n0 = n_stdw;
    run_load(4, 0, ROWS, 1'b1, nc);
    chk("ld_cycles", nc, ROWS);
    settle();
    chk("stdw_count", n_stdw - n0, ROWS);
    chk("cv_10", core_valid, 8'h10);
    chk("busy_ld_end", busy_ld, 1'b0);

    // reload core 4 with toggling valid
    issue(1, 4, 0, 0, 0, 0, 0, 0, 1'b0, "ld4t");
    exp_valid[4] = 1'b0;
    n0 = n_stdw;
    run_load(4, 1, ROWS, 1'b0, nc);
    settle();
    chk("stdw_count_t", n_stdw - n0, ROWS);
    chk("q_empty_t", exp_q.size(), 0);

    do_read(4, 35);

    // compute core 4 concurrent with load of core 3
    issue(1, 3, 0, 0, 0, 1, 4, 10, 1'b0, "cmp_ld");
    exp_valid[3] = 1'b0;
    fork
      run_load(3, 0, ROWS, 1'b0, nc);
      check_cmp(4, 10);
    join
    settle();
    chk("cv_18", core_valid, 8'h18);

    // rejections while core 3 reloads
    issue(1, 3, 0, 0, 0, 0, 0, 0, 1'b0, "ld3r");
    exp_valid[3] = 1'b0;
    fork
      run_load(3, 1, ROWS, 1'b0, nc);
      begin
        repeat (4) @(negedge clk);
        issue(0, 0, 0, 0, 0, 1, 3, 5, 1'b1, "cmp_loading");
        chk("no_busy_cmp", busy_cmp, 1'b0);
        issue(0, 0, 1, 0, 1, 0, 0, 0, 1'b1, "rd_loading");
        chk("no_stdr", STDR, 1'b0);
        issue(1, 6, 0, 0, 0, 0, 0, 0, 1'b1, "ld_loading");
        chk("std_core_kept", STD_Core_A, 3);
      end
    join
    settle();

    // ld on the computing core, and cmp while busy
    issue(0, 0, 0, 0, 0, 1, 4, 20, 1'b0, "cmp4");
    fork
      check_cmp(4, 20);
      begin
        repeat (3) @(negedge clk);
        issue(1, 4, 0, 0, 0, 0, 0, 0, 1'b1, "ld_computing");
        chk("no_busy_ld", busy_ld, 1'b0);
        issue(0, 0, 0, 0, 0, 1, 3, 4, 1'b1, "cmp_busy");
      end
    join

    issue(0, 0, 0, 0, 0, 1, 4, 0, 1'b1, "beats0");
    chk("beats0_idle", busy_cmp, 1'b0);
    issue(0, 0, 0, 0, 0, 1, 7, 5, 1'b1, "cmp_invalid");
    chk("invalid_idle", act_en, 1'b0);

    // same-core same-cycle: compute wins, load rejected
    issue(1, 4, 0, 0, 0, 1, 4, 6, 1'b1, "same_core");
    chk("same_core_noload", busy_ld, 1'b0);
    check_cmp(4, 6);

    // ld and rd together: load wins
    issue(1, 1, 1, 4, 3, 0, 0, 0, 1'b1, "ld_rd");
    chk("ld_rd_nostdr", STDR, 1'b0);
    chk("ld_rd_busy", busy_ld, 1'b1);
    exp_valid[1] = 1'b0;
    run_load(1, 0, ROWS, 1'b0, nc);
    settle();

    // randomized concurrent traffic
    for (int r = 0; r < 6; r++) begin
      int lc, cc, nb, s, c;
      lc = $urandom_range(0, 7);
      s = $urandom_range(0, 7);
      cc = -1;
      for (int t = 0; t < 8; t++) begin
        c = (s + t) % 8;
        if (cc < 0 && c != lc && exp_valid[c]) cc = c;
      end
      nb = $urandom_range(1, 40);
      if (cc >= 0) issue(1, lc, 0, 0, 0, 1, cc, nb, 1'b0, "rnd_both");
      else issue(1, lc, 0, 0, 0, 0, 0, 0, 1'b0, "rnd_ld");
      exp_valid[lc] = 1'b0;
      fork
        run_load(lc, 2, ROWS, 1'b0, nc);
        if (cc >= 0) check_cmp(cc, nb);
      join
      settle();
      do_read($urandom_range(0, 7), $urandom_range(0, 63));
    end
    chk("q_empty_rnd", exp_q.size(), 0);

    // asynchronous reset in the middle of a load
    issue(1, 5, 0, 0, 0, 0, 0, 0, 1'b0, "ld5");
    exp_valid[5] = 1'b0;
    run_load(5, 0, 20, 1'b0, nc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_valid = '0;
    #1;
    chk("midrst_ctl", ctl_vec, 30'h0);
    chk("midrst_wdata", weight_in, 288'h0);
    chk("midrst_cv", core_valid, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    issue(1, 2, 0, 0, 0, 0, 0, 0, 1'b0, "ld2");
    run_load(2, 2, ROWS, 1'b0, nc);
    settle();
    chk("final_cv", core_valid, 8'h04);
    chk("q_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cim_sched.md
Name: cim_sched

Overview:
- Scheduler/sequencer in front of the CIM unit (8 cores × 64 weight rows, one standby-write/read port, one compute-core select).
- Runs two concurrent engines: a storage engine (64-row weight load or single-row readback on the STD port) and a compute engine (N activation beats on the CIM port).
- Enforces ping-pong use of the cores: a core cannot be written while it computes, and cannot compute until it is fully loaded.
- Tracks per-core weight validity.

Parameters:
- N_CORE, 8, number of CIM cores.
- CORE_AW, 3, core address width.
- ROWS, 64, weight rows per core.
- ROW_AW, 6, row address width.
- W_WIDTH, 288, weight row width (72 × 4b).
- PSUM_LAT, 1, cycles from act_en to valid PSUM at the CIM unit, range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  request a full ROWS-row load into ld_core.
- ld_core  in  CORE_AW  target core for the load.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid & w_ready.
- w_data  in  W_WIDTH  weight row.
- rd_req  in  1  single-row readback request.
- rd_core  in  CORE_AW  readback core.
- rd_row  in  ROW_AW  readback row.
- rd_valid  out  1  weight_out from the CIM unit is valid this cycle.
- cmp_start  in  1  compute request.
- cmp_core  in  CORE_AW  compute core.
- cmp_beats  in  8  number of activation beats (1..255).
- psum_valid  out  1  PSUM from the CIM unit is valid this cycle.
- cmp_done  out  1  pulse coincident with the last psum_valid.
- busy_ld  out  1  storage engine not idle.
- busy_cmp  out  1  compute engine not idle.
- err_reject  out  1  one-cycle pulse when a request is rejected.
- core_valid  out  N_CORE  bitmap of fully loaded cores.
- STDW  out  1  to CIM unit, standby write.
- STDR  out  1  to CIM unit, standby read.
- STD_Core_A  out  CORE_AW  to CIM unit, standby core.
- STD_row_A  out  ROW_AW  to CIM unit, standby row.
- weight_in  out  W_WIDTH  to CIM unit, registered w_data.
- CIM_Core_A  out  CORE_AW  to CIM unit, compute core.
- act_en  out  1  activation beat strobe; upstream presents act_in1..3 on it.

Behaviour:
- Reset: every output is 0, including core_valid, the row counter and the beat counter. Both FSMs go to IDLE. Reset mid-operation aborts any load or compute; a partially loaded core stays invalid.
- All CIM-facing outputs are registered.
- Storage FSM states: S_IDLE, S_LOAD, S_READ.
  - S_IDLE -> S_LOAD on an accepted ld_start. At acceptance: latch STD_Core_A = ld_core, set the row counter to 0, clear core_valid[ld_core].
  - S_LOAD: w_ready = 1. Each accepted beat produces STDW = 1, STD_row_A = row counter and weight_in = w_data on the next edge (latency 1), then the counter increments.
  - An idle w_valid produces STDW = 0; the row is held, with no gap penalty beyond the stall.
  - The beat at row ROWS-1 sets core_valid[STD_Core_A] on the same edge it drives STDW. The FSM returns to S_IDLE on that edge; the counter wraps to 0 and does not advance further.
  - S_IDLE -> S_READ on an accepted rd_req: STDR = 1 for one cycle with STD_Core_A/STD_row_A from the request. rd_valid pulses the following cycle. Then S_IDLE.
  - w_ready = 0 outside S_LOAD.
- Compute FSM states: C_IDLE, C_RUN.
  - Accepted cmp_start latches CIM_Core_A = cmp_core and loads the beat counter with cmp_beats.
  - C_RUN: act_en = 1 for exactly cmp_beats consecutive cycles, starting the cycle after acceptance.
  - psum_valid = act_en delayed by PSUM_LAT. cmp_done = the final psum_valid.
  - busy_cmp stays high until cmp_done.
  - CIM_Core_A holds its last value while idle.
- Acceptance rules (any rejection pulses err_reject the next cycle and has no other effect):
  - ld_start: only in S_IDLE, and ld_core != CIM_Core_A while busy_cmp.
  - rd_req: only in S_IDLE, and not on the same cycle as ld_start (load wins).
  - cmp_start: only when busy_cmp = 0 and cmp_beats != 0 and core_valid[cmp_core] = 1. A core currently in S_LOAD is invalid, so it is rejected automatically.
  - Same-cycle ld_start and cmp_start on the same core: compute is evaluated first against the current state; the load is then rejected as a conflict. On different cores, both are accepted.
  - Requests while busy are rejected, not queued.
- Overlap: load of core A and compute on core B run concurrently with no throughput loss.

Decomposition:
- Package cim_pkg holds:
  - CORE_AW, ROW_AW, ROWS, W_WIDTH;
  - the enum typedefs st_state_t {S_IDLE, S_LOAD, S_READ} and cmp_state_t {C_IDLE, C_RUN}.
- One natural sub-module: cim_psum_delay, a PSUM_LAT-deep shift register producing psum_valid/cmp_done from act_en and the last-beat flag.

Test Plan:
- Reset, then ld_start core 4 with 64 back-to-back beats (w_data = 288'h111…1):
  - STDW high 64 cycles, STD_row_A 0..63, STD_Core_A = 4;
  - core_valid = 8'h10 after the last beat; busy_ld falls.
- Load core 4 with w_valid toggling 1/0:
  - exactly 64 STDW pulses, rows contiguous;
  - core_valid[4] set only on the 64th beat.
- rd_req core 4 row 35 -> STDR one cycle with STD_row_A = 35; rd_valid the next cycle.
- cmp_start core 4 with 10 beats concurrent with ld_start core 3:
  - act_en for 10 cycles, CIM_Core_A = 4;
  - psum_valid 10 cycles delayed by PSUM_LAT;
  - cmp_done on the 10th;
  - core 3 loads in parallel and ends with core_valid = 8'h18.
- Rejections, each -> err_reject pulse and no state change:
  - cmp_start on core 3 while it is loading;
  - ld_start on core 4 while it computes;
  - cmp_beats = 0;
  - rd_req during S_LOAD.
- Assert rst mid-load at row 20:
  - all outputs 0 asynchronously, core_valid = 0;
  - a subsequent full load completes normally.
